// File: rtl/mem_access_ctrl_pkg.sv
// Shared types, opcodes and decode helpers for the MEM-stage data-memory access controller.
package mem_access_ctrl_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned OPC_W  = 6;

   localparam logic [OPC_W-1:0] OPCODE_LB  = 6'h20;
   localparam logic [OPC_W-1:0] OPCODE_LH  = 6'h21;
   localparam logic [OPC_W-1:0] OPCODE_LW  = 6'h23;
   localparam logic [OPC_W-1:0] OPCODE_LBU = 6'h24;
   localparam logic [OPC_W-1:0] OPCODE_LHU = 6'h25;
   localparam logic [OPC_W-1:0] OPCODE_LWU = 6'h27;
   localparam logic [OPC_W-1:0] OPCODE_SB  = 6'h28;
   localparam logic [OPC_W-1:0] OPCODE_SH  = 6'h29;
   localparam logic [OPC_W-1:0] OPCODE_SW  = 6'h2B;

   localparam logic [BE_W-1:0] MEM_BE_ALL = 4'b1111;

   typedef enum logic [1:0] {
      MEM_ST_IDLE = 2'd0,
      MEM_ST_WAIT = 2'd1,
      MEM_ST_DONE = 2'd2
   } mem_state_e;

   typedef enum logic [1:0] {
      MEM_SIZE_B = 2'd0,
      MEM_SIZE_H = 2'd1,
      MEM_SIZE_W = 2'd2
   } mem_size_e;

   typedef struct packed {
      logic      valid;
      mem_size_e size;
      logic      sext;
   } mem_dec_t;

   // Access attributes latched at acceptance and held for the whole bus cycle.
   typedef struct packed {
      logic      we;
      mem_size_e size;
      logic      sext;
      logic [1:0] off;
   } mem_op_t;

   function automatic mem_dec_t mem_decode(input logic [OPC_W-1:0] opcode);
      mem_dec_t d;
      d = '{valid: 1'b1, size: MEM_SIZE_W, sext: 1'b0};
      case (opcode)
         OPCODE_LB:             d = '{valid: 1'b1, size: MEM_SIZE_B, sext: 1'b1};
         OPCODE_LBU, OPCODE_SB: d = '{valid: 1'b1, size: MEM_SIZE_B, sext: 1'b0};
         OPCODE_LH:             d = '{valid: 1'b1, size: MEM_SIZE_H, sext: 1'b1};
         OPCODE_LHU, OPCODE_SH: d = '{valid: 1'b1, size: MEM_SIZE_H, sext: 1'b0};
         OPCODE_LW, OPCODE_LWU,
         OPCODE_SW:             d = '{valid: 1'b1, size: MEM_SIZE_W, sext: 1'b0};
         default:               d = '{valid: 1'b0, size: MEM_SIZE_W, sext: 1'b0};
      endcase
      return d;
   endfunction

   function automatic logic mem_aligned(input mem_size_e size, input logic [1:0] off);
      case (size)
         MEM_SIZE_H: return (off[0] == 1'b0);
         MEM_SIZE_W: return (off == 2'b00);
         default:    return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory req/ack bus between the MEM-stage controller and the memory.
interface mem_access_ctrl_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        be;
   logic [31:0]       wdata;
   logic              ack;
   logic [31:0]       rdata;

   modport master (output req, we, addr, be, wdata, input ack, rdata);
   modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_ctrl_load_extender.sv
// Load lane select plus sign/zero extension; purely combinational so the WB checker can reuse it.
module mem_access_ctrl_load_extender
   import mem_access_ctrl_pkg::*;
(
   input  logic [DATA_W-1:0] word,
   input  mem_size_e         size,
   input  logic              sext,
   input  logic [1:0]        off,
   output logic [DATA_W-1:0] data_c
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = word[7:0];
      case (off)
         2'd1:    byte_lane = word[15:8];
         2'd2:    byte_lane = word[23:16];
         2'd3:    byte_lane = word[31:24];
         default: byte_lane = word[7:0];
      endcase
      half_lane = off[1] ? word[31:16] : word[15:0];

      data_c = word;
      case (size)
         MEM_SIZE_B: data_c = sext ? {{24{byte_lane[7]}}, byte_lane} : {24'd0, byte_lane};
         MEM_SIZE_H: data_c = sext ? {{16{half_lane[15]}}, half_lane} : {16'd0, half_lane};
         default:    data_c = word;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: sizes/aligns loads and stores, runs the req/ack
// handshake with timeout, and stalls the pipeline until each access resolves.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
)(
   input  logic              clk,
   input  logic              i_rst,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic [OPC_W-1:0]  i_opcode,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_stall,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_rvalid,
   output logic              o_misaligned,
   output logic              o_bus_err,
   mem_access_ctrl_if.master mem
);

   mem_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   mem_op_t           op_q, op_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              misaligned_q, misaligned_d;
   logic              bus_err_q, bus_err_d;
   logic              stall_c;

   mem_dec_t          dec;
   logic [BE_W-1:0]   st_be;
   logic [DATA_W-1:0] st_wdata;
   logic [DATA_W-1:0] ld_data_c;

   mem_access_ctrl_load_extender u_load_extender (
      .word   (mem.rdata),
      .size   (op_q.size),
      .sext   (op_q.sext),
      .off    (op_q.off),
      .data_c (ld_data_c)
   );

   // Store lane placement from the incoming request.
   always_comb begin
      dec      = mem_decode(i_opcode);
      st_be    = MEM_BE_ALL;
      st_wdata = i_wdata;
      case (dec.size)
         MEM_SIZE_B: begin
            st_be    = BE_W'(4'b0001 << i_addr[1:0]);
            st_wdata = {4{i_wdata[7:0]}};
         end
         MEM_SIZE_H: begin
            st_be    = i_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{i_wdata[15:0]}};
         end
         default: begin
            st_be    = MEM_BE_ALL;
            st_wdata = i_wdata;
         end
      endcase
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_d         = op_q;
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      rvalid_d     = 1'b0;
      misaligned_d = 1'b0;
      bus_err_d    = 1'b0;
      stall_c      = 1'b0;

      case (state_q)
         MEM_ST_IDLE: begin
            if (i_mem_read || i_mem_write) begin
               if (dec.valid && mem_aligned(dec.size, i_addr[1:0])) begin
                  stall_c = 1'b1;
                  state_d = MEM_ST_WAIT;
                  cnt_d   = '0;
                  req_d   = 1'b1;
                  we_d    = i_mem_write;
                  addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
                  be_d    = i_mem_write ? st_be : MEM_BE_ALL;
                  wdata_d = i_mem_write ? st_wdata : '0;
                  op_d    = '{we: i_mem_write, size: dec.size, sext: dec.sext, off: i_addr[1:0]};
               end else begin
                  misaligned_d = 1'b1;
               end
            end
         end
         MEM_ST_WAIT: begin
            stall_c = 1'b1;
            if (mem.ack) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = MEM_ST_DONE;
               if (!op_q.we) begin
                  rvalid_d = 1'b1;
                  rdata_d  = ld_data_c;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               req_d     = 1'b0;
               cnt_d     = '0;
               bus_err_d = 1'b1;
               rdata_d   = '0;
               state_d   = MEM_ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         MEM_ST_DONE: begin
            state_d = MEM_ST_IDLE;
         end
         default: begin
            state_d = MEM_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q      <= MEM_ST_IDLE;
         cnt_q        <= '0;
         op_q         <= '0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         be_q         <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         rvalid_q     <= 1'b0;
         misaligned_q <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_q         <= op_d;
         req_q        <= req_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         be_q         <= be_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         rvalid_q     <= rvalid_d;
         misaligned_q <= misaligned_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign o_stall      = stall_c;
   assign o_rdata      = rdata_q;
   assign o_rvalid     = rvalid_q;
   assign o_misaligned = misaligned_q;
   assign o_bus_err    = bus_err_q;
   assign mem.req      = req_q;
   assign mem.we       = we_q;
   assign mem.addr     = addr_q;
   assign mem.be       = be_q;
   assign mem.wdata    = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a latency-programmable memory model.
module tb_mem_access_ctrl;
   import mem_access_ctrl_pkg::*;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned CNT_W   = 5;

   typedef struct {
      logic        rv, mis, berr, we;
      logic [31:0] rdata, addr, wdata;
      logic [3:0]  be;
      int          stall_n, req_n;
   } exp_t;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_mem_read, i_mem_write;
   logic [5:0]  i_opcode;
   logic [31:0] i_addr, i_wdata;
   logic        o_stall, o_rvalid, o_misaligned, o_bus_err;
   logic [31:0] o_rdata;

   int          n_chk  = 0;
   int          n_fail = 0;
   exp_t        sb_q[$];

   int          mem_lat   = 0;
   logic [31:0] mem_word  = '0;
   logic        stray_ack = 1'b0;

   mem_access_ctrl_if #(.ADDR_W(ADDR_W)) mem_if ();

   mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .i_rst        (i_rst),
      .i_mem_read   (i_mem_read),
      .i_mem_write  (i_mem_write),
      .i_opcode     (i_opcode),
      .i_addr       (i_addr),
      .i_wdata      (i_wdata),
      .o_stall      (o_stall),
      .o_rdata      (o_rdata),
      .o_rvalid     (o_rvalid),
      .o_misaligned (o_misaligned),
      .o_bus_err    (o_bus_err),
      .mem          (mem_if)
   );

   always #5 clk = ~clk;

   // Memory: acks on the mem_lat-th cycle of a held request; mem_lat==0 never acks.
   initial begin
      int wcnt;
      wcnt = 0;
      mem_if.ack   = 1'b0;
      mem_if.rdata = 32'h0BAD_F00D;
      forever begin
         @(posedge clk);
         #1;
         mem_if.ack = stray_ack;
         if (mem_if.req) begin
            wcnt++;
            if (mem_lat != 0 && wcnt == mem_lat) begin
               mem_if.ack   = 1'b1;
               mem_if.rdata = mem_word;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic rd, input logic wr, input logic [5:0] opc,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input int lat, input logic [31:0] word);
      exp_t e;
      int   sz;
      bit   sx;
      logic [7:0]  b;
      logic [15:0] h;
      sz = 0;
      sx = 1'b0;
      case (opc)
         6'h20: begin sz = 1; sx = 1'b1; end
         6'h24: sz = 1;
         6'h21: begin sz = 2; sx = 1'b1; end
         6'h25: sz = 2;
         6'h23, 6'h27: sz = 4;
         6'h28: sz = 1;
         6'h29: sz = 2;
         6'h2B: sz = 4;
         default: sz = 0;
      endcase
      e = '{rv: 1'b0, mis: 1'b0, berr: 1'b0, we: 1'b0, rdata: '0, addr: '0, wdata: '0,
            be: '0, stall_n: 0, req_n: 0};
      if (!(rd || wr)) return e;
      if (sz == 0 || (addr & 32'(sz - 1)) != 0) begin
         e.mis = 1'b1;
         return e;
      end
      e.we   = wr;
      e.addr = addr & 32'hFFFF_FFFC;
      if (!wr)          e.be = 4'hF;
      else if (sz == 1) e.be = 4'(1 << addr[1:0]);
      else if (sz == 2) e.be = addr[1] ? 4'hC : 4'h3;
      else              e.be = 4'hF;
      e.wdata = (sz == 1) ? {4{wdata[7:0]}} : (sz == 2) ? {2{wdata[15:0]}} : wdata;
      if (lat == 0) begin
         e.berr    = 1'b1;
         e.stall_n = TIMEOUT + 1;
         e.req_n   = TIMEOUT;
         e.rdata   = '0;
      end else begin
         e.stall_n = lat + 1;
         e.req_n   = lat;
         if (!wr) begin
            e.rv = 1'b1;
            b = 8'(word >> (8 * addr[1:0]));
            h = 16'(word >> (16 * addr[1]));
            if (sz == 1)      e.rdata = sx ? 32'($signed(b)) : 32'(b);
            else if (sz == 2) e.rdata = sx ? 32'($signed(h)) : 32'(h);
            else              e.rdata = word;
         end
      end
      return e;
   endfunction

   task automatic clear_inputs();
      i_mem_read  = 1'b0;
      i_mem_write = 1'b0;
      i_opcode    = 6'h00;
      i_addr      = '0;
      i_wdata     = '0;
   endtask

   task automatic run_access(input string tag, input logic rd, input logic wr,
                             input logic [5:0] opc, input logic [31:0] addr,
                             input logic [31:0] wdata, input int lat, input logic [31:0] word);
      exp_t        e;
      int          stall_n, req_n;
      bit          done, bus_seen, unstable;
      logic [31:0] a0, wd0, rd_obs;
      logic [3:0]  be0;
      logic        we0, rv, mis, berr;
      stall_n = 0; req_n = 0; done = 0; bus_seen = 0; unstable = 0;
      a0 = '0; wd0 = '0; rd_obs = '0; be0 = '0; we0 = 1'b0; rv = 1'b0; mis = 1'b0; berr = 1'b0;
      sb_q.push_back(model(rd, wr, opc, addr, wdata, lat, word));
      mem_lat  = lat;
      mem_word = word;
      @(posedge clk);
      #1;
      i_mem_read = rd; i_mem_write = wr; i_opcode = opc; i_addr = addr; i_wdata = wdata;
      for (int c = 0; c < int'(TIMEOUT) + 16 && !done; c++) begin
         @(negedge clk);
         if (o_stall) stall_n++;
         if (mem_if.req) begin
            req_n++;
            if (!bus_seen) begin
               bus_seen = 1; a0 = mem_if.addr; be0 = mem_if.be; we0 = mem_if.we; wd0 = mem_if.wdata;
            end else if (mem_if.addr !== a0 || mem_if.be !== be0 || mem_if.we !== we0 ||
                         mem_if.wdata !== wd0) begin
               unstable = 1;
            end
         end
         if (o_rvalid || o_misaligned || o_bus_err || (stall_n > 0 && !o_stall)) begin
            done = 1; rv = o_rvalid; mis = o_misaligned; berr = o_bus_err; rd_obs = o_rdata;
         end
         if (!o_stall) begin
            @(posedge clk);
            #1;
            clear_inputs();
         end
      end
      if (!done) begin
         check({tag, ".complete"}, 32'd0, 32'd1);
         clear_inputs();
      end
      e = sb_q.pop_front();
      check({tag, ".rvalid"}, 32'(rv), 32'(e.rv));
      check({tag, ".misaligned"}, 32'(mis), 32'(e.mis));
      check({tag, ".bus_err"}, 32'(berr), 32'(e.berr));
      check({tag, ".stall_cycles"}, 32'(stall_n), 32'(e.stall_n));
      check({tag, ".req_cycles"}, 32'(req_n), 32'(e.req_n));
      if (e.rv || e.berr) check({tag, ".rdata"}, rd_obs, e.rdata);
      if (e.req_n > 0) begin
         check({tag, ".addr"}, a0, e.addr);
         check({tag, ".be"}, 32'(be0), 32'(e.be));
         check({tag, ".we"}, 32'(we0), 32'(e.we));
         if (e.we) check({tag, ".wdata"}, wd0, e.wdata);
         check({tag, ".bus_stable"}, 32'(unstable), 32'd0);
      end
   endtask

   initial begin
      bit          seen;
      logic [5:0]  opcs [9];
      logic [5:0]  op;
      logic [31:0] a;
      bit          st;
      opcs = '{OPCODE_LB, OPCODE_LH, OPCODE_LW, OPCODE_LBU, OPCODE_LHU, OPCODE_LWU,
               OPCODE_SB, OPCODE_SH, OPCODE_SW};
      clear_inputs();
      i_rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.stall", 32'(o_stall), 32'd0);
      check("reset.pulses", {29'd0, o_rvalid, o_misaligned, o_bus_err}, 32'd0);
      check("reset.req_we", {30'd0, mem_if.req, mem_if.we}, 32'd0);
      check("reset.be", 32'(mem_if.be), 32'd0);
      check("reset.addr", mem_if.addr, 32'd0);
      check("reset.wdata", mem_if.wdata, 32'd0);
      check("reset.rdata", o_rdata, 32'd0);
      @(posedge clk);
      #1;
      i_rst = 1'b0;

      run_access("lw_basic",  1, 0, OPCODE_LW,  32'h104, 32'h0, 3, 32'hDEADBEEF);
      run_access("lb_sext",   1, 0, OPCODE_LB,  32'h203, 32'h0, 1, 32'h80AA5511);
      run_access("lbu_zext",  1, 0, OPCODE_LBU, 32'h203, 32'h0, 2, 32'h80AA5511);
      run_access("lh_sext",   1, 0, OPCODE_LH,  32'h202, 32'h0, 2, 32'h80AA5511);
      run_access("lhu_zext",  1, 0, OPCODE_LHU, 32'h200, 32'h0, 1, 32'h7F00F123);
      run_access("lwu",       1, 0, OPCODE_LWU, 32'h208, 32'h0, 4, 32'h89ABCDEF);
      run_access("sb_lane1",  0, 1, OPCODE_SB,  32'h011, 32'h123456C3, 2, 32'h0);
      run_access("sh_upper",  0, 1, OPCODE_SH,  32'h012, 32'h123456C3, 1, 32'h0);
      run_access("sw_rdwr",   1, 1, OPCODE_SW,  32'h020, 32'hCAFEF00D, 1, 32'h0);
      run_access("lw_misal",  1, 0, OPCODE_LW,  32'h102, 32'h0, 1, 32'h0);
      run_access("lh_misal",  1, 0, OPCODE_LH,  32'h201, 32'h0, 1, 32'h0);
      run_access("sw_misal",  0, 1, OPCODE_SW,  32'h041, 32'h5, 1, 32'h0);
      run_access("non_mem",   1, 0, 6'h00,      32'h100, 32'h0, 1, 32'h0);
      run_access("sw_timeout",0, 1, OPCODE_SW,  32'h300, 32'h11223344, 0, 32'h0);
      run_access("lw_after_to",1, 0, OPCODE_LW, 32'h304, 32'h0, 2, 32'h13579BDF);

      for (int i = 0; i < 8; i++) begin
         op = opcs[$urandom_range(0, 8)];
         st = (op == OPCODE_SB || op == OPCODE_SH || op == OPCODE_SW);
         a  = $urandom & 32'h0000_FFFF;
         if (op == OPCODE_LH || op == OPCODE_LHU || op == OPCODE_SH) a[0] = 1'b0;
         if (op == OPCODE_LW || op == OPCODE_LWU || op == OPCODE_SW) a[1:0] = 2'b00;
         run_access("rand", !st, st, op, a, $urandom, int'($urandom_range(1, 4)), $urandom);
      end

      // Reset during the second WAIT cycle, then a stray ack while idle.
      mem_lat = 0;
      @(posedge clk);
      #1;
      i_mem_read = 1'b1; i_opcode = OPCODE_LW; i_addr = 32'h400;
      @(posedge clk);
      @(posedge clk);
      #1;
      i_rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      check("rst_mid.req_before", 32'(mem_if.req), 32'd1);
      @(negedge clk);
      check("rst_mid.req", 32'(mem_if.req), 32'd0);
      check("rst_mid.stall", 32'(o_stall), 32'd0);
      check("rst_mid.outputs", {27'd0, o_rvalid, o_misaligned, o_bus_err, mem_if.we, |mem_if.be},
            32'd0);
      check("rst_mid.addr", mem_if.addr, 32'd0);
      stray_ack = 1'b1;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         stray_ack = 1'b0;
         if (mem_if.req || o_stall || o_rvalid || o_bus_err || o_misaligned) seen = 1;
      end
      check("rst_mid.late_ack_ignored", 32'(seen), 32'd0);

      run_access("lw_after_rst", 1, 0, OPCODE_LW, 32'h500, 32'h0, 1, 32'hA5A5_5A5A);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
